// File: rtl/std_mem_d1_copy.sv
// Sequential copy engine: reads words from a source std_mem_d1 over its combinational
// read port and writes them to a destination std_mem_d1 using the write_en/done handshake.
module std_mem_d1_copy #(
    parameter int width    = 32,
    parameter int size     = 16,
    parameter int idx_size = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [idx_size-1:0] src_base,
    input  logic [idx_size-1:0] dst_base,
    input  logic [idx_size:0]   len,
    output logic [idx_size-1:0] src_addr0,
    input  logic [width-1:0]    src_read_data,
    output logic [idx_size-1:0] dst_addr0,
    output logic [width-1:0]    dst_write_data,
    output logic                dst_write_en,
    input  logic                dst_done,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [idx_size:0] one = {{idx_size{1'b0}}, 1'b1};

    state_t              state, state_next;
    logic [idx_size:0]   i, i_inc;
    logic [idx_size:0]   len_r;
    logic [idx_size-1:0] src_base_r, dst_base_r;
    logic [width-1:0]    data_r;

    // Memory depth is not checked; addresses simply wrap modulo 2^idx_size.
    logic size_unused;
    assign size_unused = (size > 0);

    assign i_inc = i + one;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            i          <= '0;
            data_r     <= '0;
            len_r      <= '0;
            src_base_r <= '0;
            dst_base_r <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        src_base_r <= src_base;
                        dst_base_r <= dst_base;
                        len_r      <= len;
                        i          <= '0;
                    end
                end
                S_READ: data_r <= src_read_data;
                S_WAIT: begin
                    if (dst_done) i <= i_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        src_addr0      = '0;
        dst_addr0      = '0;
        dst_write_data = '0;
        dst_write_en   = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) state_next = (len == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                src_addr0  = src_base_r + i[idx_size-1:0];
                state_next = S_WRITE;
            end
            S_WRITE: begin
                dst_write_en   = 1'b1;
                dst_addr0      = dst_base_r + i[idx_size-1:0];
                dst_write_data = data_r;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (dst_done) state_next = (i_inc == len_r) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Directed bench for std_mem_d1_copy: behavioural source/destination memories with a
// configurable acknowledge delay, a vector table of copies and hand-written corner sequences.
module tb_std_mem_d1_copy;

    logic        clk = 1'b0;
    logic        reset, go;
    logic [3:0]  src_base, dst_base;
    logic [4:0]  len;
    logic [3:0]  src_addr0, dst_addr0;
    logic [31:0] src_read_data, dst_write_data;
    logic        dst_write_en, dst_done, busy, done;

    std_mem_d1_copy #(.width(32), .size(16), .idx_size(4)) dut (
        .clk(clk), .reset(reset), .go(go),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .src_addr0(src_addr0), .src_read_data(src_read_data),
        .dst_addr0(dst_addr0), .dst_write_data(dst_write_data),
        .dst_write_en(dst_write_en), .dst_done(dst_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] src_mem [16];
    logic [31:0] dst_mem [16];
    logic        clear_dst = 1'b0;
    logic        stray = 1'b0;
    int          ack_delay = 1;
    int          cnt = 0;

    assign src_read_data = src_mem[src_addr0];
    assign dst_done      = (cnt == 1) || stray;

    // Destination stub: write lands on the strobe edge, acknowledge after ack_delay cycles.
    always @(posedge clk) begin
        if (clear_dst) begin
            for (int j = 0; j < 16; j++) dst_mem[j] <= 32'hDEAD0000 | j;
        end else if (dst_write_en) begin
            dst_mem[dst_addr0] <= dst_write_data;
        end
        if (dst_write_en) cnt <= ack_delay;
        else if (cnt > 0) cnt <= cnt - 1;
    end

    int wr_total = 0, done_total = 0, busy_total = 0;
    int done_q[$];
    always @(negedge clk) begin
        if (dst_write_en) wr_total++;
        if (busy) busy_total++;
        if (done) begin
            done_total++;
            done_q.push_back(cyc);
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0] sb;
        logic [3:0] db;
        logic [4:0] ln;
        int         delay;
        int         stray_at;
        int         exp_done;
        string      name;
    } vec_t;

    task automatic run_copy(input vec_t v);
        logic [31:0] exp_mem [16];
        int start, wr0, dn0, bz0, bad, done_at;
        bit seen;
        ack_delay = v.delay;
        clear_dst = 1'b1;
        tick();
        clear_dst = 1'b0;
        for (int j = 0; j < 16; j++) exp_mem[j] = 32'hDEAD0000 | j;
        for (int k = 0; k < int'(v.ln); k++) exp_mem[(v.db + k) % 16] = src_mem[(v.sb + k) % 16];
        wr0 = wr_total; dn0 = done_total; bz0 = busy_total;
        src_base = v.sb; dst_base = v.db; len = v.ln; go = 1'b1;
        start = cyc;
        seen = 0;
        for (int t = 1; t <= 400; t++) begin
            tick();
            go    = 1'b0;
            stray = (t == v.stray_at);
            if (done) begin
                seen = 1;
                break;
            end
        end
        stray = 1'b0;
        tick();
        done_at = (done_total > dn0) ? done_q[done_q.size() - 1] - start : -1;
        check({v.name, " done seen"}, seen, 1);
        check({v.name, " done cycle"}, done_at, v.exp_done);
        check({v.name, " done pulses"}, done_total - dn0, 1);
        check({v.name, " write_en pulses"}, wr_total - wr0, v.ln);
        check({v.name, " busy cycles"}, busy_total - bz0, v.exp_done);
        check({v.name, " idle after"}, {busy, done, dst_write_en}, 0);
        bad = 0;
        for (int j = 0; j < 16; j++) if (dst_mem[j] !== exp_mem[j]) bad++;
        check({v.name, " dst words wrong"}, bad, 0);
    endtask

    vec_t vecs [7];

    initial begin
        int wr0, dn0, start;
        vecs[0] = '{4'd2,  4'd7,  5'd4,  1, 0, 13, "basic"};
        vecs[1] = '{4'd0,  4'd0,  5'd0,  1, 0, 1,  "zero_len"};
        vecs[2] = '{4'd14, 4'd15, 5'd3,  1, 0, 10, "wrap"};
        vecs[3] = '{4'd6,  4'd1,  5'd16, 1, 0, 49, "full"};
        vecs[4] = '{4'd2,  4'd0,  5'd4,  4, 1, 25, "slow_ack"};
        vecs[5] = '{4'd9,  4'd12, 5'd5,  2, 0, 21, "ack2"};
        vecs[6] = '{4'd4,  4'd3,  5'd1,  1, 0, 4,  "after_reset"};

        for (int a = 0; a < 16; a++) src_mem[a] = 32'(a + 8);
        reset = 1'b1; go = 1'b0; src_base = '0; dst_base = '0; len = '0;
        tick();
        tick();
        check("reset outputs", {src_addr0, dst_addr0, dst_write_data, dst_write_en, busy, done}, 0);
        reset = 1'b0;
        tick();
        check("idle outputs", {src_addr0, dst_addr0, dst_write_data, dst_write_en, busy, done}, 0);

        for (int n = 0; n < 6; n++) run_copy(vecs[n]);

        // Reset during the WAIT of word 2 (cycle 9).
        ack_delay = 1;
        clear_dst = 1'b1;
        tick();
        clear_dst = 1'b0;
        wr0 = wr_total; dn0 = done_total;
        src_base = 4'd0; dst_base = 4'd0; len = 5'd8; go = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            go = 1'b0;
        end
        check("mid wait busy", {busy, dst_write_en}, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset outputs", {src_addr0, dst_addr0, dst_write_data, dst_write_en, busy, done}, 0);
        for (int t = 0; t < 20; t++) tick();
        check("mid reset no done", done_total - dn0, 0);
        check("mid reset writes", wr_total - wr0, 3);
        check("mid reset word2", dst_mem[2], 32'd10);
        check("mid reset word3", dst_mem[3], 32'hDEAD0003);
        run_copy(vecs[6]);

        // go held through the first done; inputs changed mid-copy.
        clear_dst = 1'b1;
        tick();
        clear_dst = 1'b0;
        wr0 = wr_total; dn0 = done_total;
        src_base = 4'd2; dst_base = 4'd7; len = 5'd2; go = 1'b1;
        start = cyc;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 2) begin
                src_base = 4'd10; dst_base = 4'd0; len = 5'd3;
            end
            if (t == 9) go = 1'b0;
            if (done_total - dn0 >= 2) break;
        end
        go = 1'b0;
        tick();
        check("b2b done count", done_total - dn0, 2);
        check("b2b first done", (done_total - dn0 >= 1) ? done_q[dn0] - start : -1, 7);
        check("b2b second done", (done_total - dn0 >= 2) ? done_q[dn0 + 1] - start : -1, 18);
        check("b2b writes", wr_total - wr0, 5);
        check("b2b dst7", dst_mem[7], 32'd10);
        check("b2b dst8", dst_mem[8], 32'd11);
        check("b2b dst0", dst_mem[0], 32'd18);
        check("b2b dst1", dst_mem[1], 32'd19);
        check("b2b dst2", dst_mem[2], 32'd20);
        check("b2b dst9", dst_mem[9], 32'hDEAD0009);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
